// File: rtl/isa_pkg.sv
// Mary/Shelley accumulator-stack ISA: opcodes, FSM states, select codes and the
// per-opcode memory/write-back control tables shared by the control units.
package isa_pkg;

  localparam logic [4:0] OP_APUT = 5'b00000;
  localparam logic [4:0] OP_SPUT = 5'b00001;
  localparam logic [4:0] OP_AADD = 5'b00010;
  localparam logic [4:0] OP_ASUB = 5'b00011;
  localparam logic [4:0] OP_SPEK = 5'b00100;
  localparam logic [4:0] OP_SPOP = 5'b00101;
  localparam logic [4:0] OP_RPOP = 5'b00110;
  localparam logic [4:0] OP_JIMM = 5'b00111;
  localparam logic [4:0] OP_JACC = 5'b01000;
  localparam logic [4:0] OP_JCMP = 5'b01001;
  localparam logic [4:0] OP_JFNC = 5'b01011;
  localparam logic [4:0] OP_LORR = 5'b01111;
  localparam logic [4:0] OP_LAND = 5'b10000;
  localparam logic [4:0] OP_BKAC = 5'b10101;
  localparam logic [4:0] OP_BKRA = 5'b10110;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  typedef enum logic [1:0] {CLS_ALU, CLS_MEM, CLS_WB, CLS_ILL} class_e;

  localparam logic [2:0] PC_NEXT    = 3'b000;
  localparam logic [2:0] PC_IMM_IND = 3'b001;
  localparam logic [2:0] PC_IMM     = 3'b010;
  localparam logic [2:0] PC_ACC     = 3'b100;
  localparam logic [2:0] PC_ACC_IND = 3'b101;
  localparam logic [2:0] PC_CMP     = 3'b110;
  localparam logic [2:0] PC_CMP_IND = 3'b111;

  localparam logic [1:0] MARY_MEM = 2'b00;
  localparam logic [1:0] MARY_ALU = 2'b01;
  localparam logic [1:0] MARY_IMM = 2'b10;

  localparam logic [1:0] SP_DEC = 2'b01;
  localparam logic [1:0] SP_INC = 2'b10;

  localparam logic       RA_MEM = 1'b0;
  localparam logic       RA_PC  = 1'b1;

  localparam logic [2:0] MSRC_MARY  = 3'b000;
  localparam logic [2:0] MSRC_RA    = 3'b001;
  localparam logic [2:0] MDST_PC    = 3'b000;
  localparam logic [2:0] MDST_IMM   = 3'b010;
  localparam logic [2:0] MDST_SPDEC = 3'b011;
  localparam logic [2:0] MDST_SP    = 3'b100;

  typedef struct packed {
    logic       reg_we;
    logic       mary_we;
    logic       shelley_we;
    logic       comp_we;
    logic       ra_we;
    logic       sp_we;
    logic [1:0] mary_src;
    logic [1:0] sp_src;
    logic       shelley_src;
    logic       ra_src;
    logic       reg_dst;
    logic       reg_data;
  } wb_ctrl_t;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [2:0] src;
    logic [2:0] dst;
  } mem_ctrl_t;

  function automatic wb_ctrl_t wb_table(input logic [4:0] op);
    wb_ctrl_t c;
    c = '0;
    case (op)
      OP_APUT: begin
        c.mary_we = 1'b1; c.mary_src = MARY_IMM; c.shelley_we = 1'b1;
      end
      OP_AADD, OP_ASUB: begin c.mary_we = 1'b1; c.mary_src = MARY_ALU; end
      OP_LORR, OP_LAND: c.comp_we = 1'b1;
      OP_SPUT: begin c.sp_we = 1'b1; c.sp_src = SP_DEC; end
      OP_SPEK: begin c.mary_we = 1'b1; c.mary_src = MARY_MEM; end
      OP_SPOP: begin
        c.mary_we = 1'b1; c.mary_src = MARY_MEM; c.sp_we = 1'b1; c.sp_src = SP_INC;
      end
      OP_RPOP: begin
        c.ra_we = 1'b1; c.ra_src = RA_MEM; c.sp_we = 1'b1; c.sp_src = SP_INC;
      end
      OP_JFNC: begin c.ra_we = 1'b1; c.ra_src = RA_PC; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic mem_ctrl_t mem_table(input logic [4:0] op);
    mem_ctrl_t m;
    m = '0;
    case (op)
      OP_SPUT: begin m.wr = 1'b1; m.src = MSRC_MARY; m.dst = MDST_SPDEC; end
      OP_SPEK, OP_SPOP, OP_RPOP: begin m.rd = 1'b1; m.dst = MDST_SP; end
      OP_BKAC: begin m.wr = 1'b1; m.src = MSRC_MARY; m.dst = MDST_IMM; end
      OP_BKRA: begin m.wr = 1'b1; m.src = MSRC_RA; m.dst = MDST_IMM; end
      default: ;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] alu_table(input logic [4:0] op);
    case (op)
      OP_AADD: return 3'b010;
      OP_ASUB: return 3'b011;
      OP_LORR: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mcu_decode.sv
// Combinational opcode classifier: instruction class, memory access, write-back
// enables/selects, ALU operation and jump target select for the current opcode.
module mcu_decode
  import isa_pkg::*;
#(
  parameter int unsigned OPCODE_W = 5,
  parameter int unsigned ALUOP_W  = 3
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                flagbit_i,
  output class_e              cls_o,
  output mem_ctrl_t           mem_o,
  output wb_ctrl_t            wb_o,
  output logic [ALUOP_W-1:0]  aluop_o,
  output logic [2:0]          pcsrc_o,
  output logic                jcmp_o
);

  logic [4:0] op;
  logic       hi_nz;

  assign op    = opcode_i[4:0];
  assign hi_nz = (opcode_i >> 5) != '0;

  always_comb begin
    cls_o   = CLS_ILL;
    pcsrc_o = PC_NEXT;
    jcmp_o  = 1'b0;
    case (op)
      OP_AADD, OP_ASUB, OP_LORR, OP_LAND: cls_o = CLS_ALU;
      OP_SPUT, OP_SPEK, OP_SPOP, OP_RPOP, OP_BKAC, OP_BKRA: cls_o = CLS_MEM;
      OP_APUT: cls_o = CLS_WB;
      OP_JIMM, OP_JFNC: begin
        cls_o   = CLS_WB;
        pcsrc_o = flagbit_i ? PC_IMM_IND : PC_IMM;
      end
      OP_JACC: begin
        cls_o   = CLS_WB;
        pcsrc_o = flagbit_i ? PC_ACC_IND : PC_ACC;
      end
      OP_JCMP: begin
        cls_o   = CLS_WB;
        pcsrc_o = flagbit_i ? PC_CMP_IND : PC_CMP;
        jcmp_o  = 1'b1;
      end
      default: ;
    endcase
    if (hi_nz) cls_o = CLS_ILL;
  end

  assign mem_o   = mem_table(op);
  assign wb_o    = wb_table(op);
  assign aluop_o = ALUOP_W'(alu_table(op));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory
// handshake stalls, fetch timeout and a sticky trap on illegal opcodes.
module multicycle_control_unit
  import isa_pkg::*;
#(
  parameter int unsigned OPCODE_W      = 5,
  parameter int unsigned ALUOP_W       = 3,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] OPCODE,
  input  logic                flagbit,
  input  logic                comp,
  input  logic                mem_ready,
  output logic                IRWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic [2:0]          MemSrc,
  output logic [2:0]          MemDst,
  output logic                RegWrite,
  output logic                MaryWrite,
  output logic                ShelleyWrite,
  output logic                CompWrite,
  output logic                RAWrite,
  output logic                PCWrite,
  output logic                SPWrite,
  output logic [1:0]          MarySrc,
  output logic [1:0]          SPSrc,
  output logic                ShelleySrc,
  output logic                RASrc,
  output logic                RegDst,
  output logic                RegData,
  output logic                SrcA,
  output logic                SrcB,
  output logic [2:0]          PCSrc,
  output logic [ALUOP_W-1:0]  ALUOP,
  output logic [2:0]          state,
  output logic                illegal
);

  localparam int unsigned    CNT_W      = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam bit             TIMEOUT_EN = (FETCH_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(FETCH_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               illegal_q;
  logic               mem_rd_q, mem_wr_q;
  logic [2:0]         mem_src_q, mem_dst_q;
  wb_ctrl_t           wb_q;
  logic               pc_we_q, jcmp_q;
  logic [2:0]         pcsrc_q;
  logic [ALUOP_W-1:0] aluop_q;
  logic               srca_q, srcb_q;

  class_e             dec_cls;
  mem_ctrl_t          dec_mem;
  wb_ctrl_t           dec_wb;
  logic [ALUOP_W-1:0] dec_aluop;
  logic [2:0]         dec_pcsrc;
  logic               dec_jcmp;

  mcu_decode #(.OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W)) u_decode (
    .opcode_i  (OPCODE),
    .flagbit_i (flagbit),
    .cls_o     (dec_cls),
    .mem_o     (dec_mem),
    .wb_o      (dec_wb),
    .aluop_o   (dec_aluop),
    .pcsrc_o   (dec_pcsrc),
    .jcmp_o    (dec_jcmp)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
          cnt_d   = '0;
        end else if (TIMEOUT_EN && cnt_q == CNT_LIMIT) begin
          state_d = ST_TRAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DECODE: begin
        case (dec_cls)
          CLS_ALU: state_d = ST_EXEC;
          CLS_MEM: state_d = ST_MEM;
          CLS_WB:  state_d = ST_WB;
          default: state_d = ST_TRAP;
        endcase
      end
      ST_EXEC: state_d = ST_WB;
      ST_MEM:  if (mem_ready) state_d = ST_WB;
      ST_WB:   state_d = ST_FETCH;
      default: state_d = ST_TRAP;
    endcase
  end

  // Outputs are loaded on the transition into the state that owns them, so each
  // appears on the first cycle of that state and write enables last one cycle.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      mem_src_q <= '0;
      mem_dst_q <= '0;
      wb_q      <= '0;
      pc_we_q   <= 1'b0;
      jcmp_q    <= 1'b0;
      pcsrc_q   <= PC_NEXT;
      aluop_q   <= '0;
      srca_q    <= 1'b0;
      srcb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= '0;
      pc_we_q <= 1'b0;
      if (state_q == ST_WB) begin
        pcsrc_q <= PC_NEXT;
        jcmp_q  <= 1'b0;
      end
      if (state_q == ST_DECODE && state_d == ST_EXEC) begin
        aluop_q <= dec_aluop;
        srca_q  <= 1'b0;
        srcb_q  <= ~flagbit;
      end
      if (state_q == ST_DECODE && state_d == ST_MEM) begin
        mem_rd_q  <= dec_mem.rd;
        mem_wr_q  <= dec_mem.wr;
        mem_src_q <= dec_mem.src;
        mem_dst_q <= dec_mem.dst;
      end
      if (state_q == ST_MEM && state_d == ST_WB) begin
        mem_rd_q  <= 1'b0;
        mem_wr_q  <= 1'b0;
        mem_src_q <= '0;
        mem_dst_q <= '0;
      end
      if (state_q != ST_WB && state_d == ST_WB) begin
        wb_q    <= dec_wb;
        pc_we_q <= 1'b1;
        pcsrc_q <= dec_pcsrc;
        jcmp_q  <= dec_jcmp;
      end
      if (state_d == ST_TRAP) illegal_q <= 1'b1;
    end
  end

  // Fetch strobe and IR load follow the state directly; JCMP falls back to PC+2
  // on the comparison flag as seen during WB itself.
  assign MemRead      = mem_rd_q | (state_q == ST_FETCH && !Reset);
  assign IRWrite      = (state_q == ST_FETCH) && mem_ready && !Reset;
  assign MemWrite     = mem_wr_q;
  assign MemSrc       = mem_src_q;
  assign MemDst       = mem_dst_q;
  assign RegWrite     = wb_q.reg_we;
  assign MaryWrite    = wb_q.mary_we;
  assign ShelleyWrite = wb_q.shelley_we;
  assign CompWrite    = wb_q.comp_we;
  assign RAWrite      = wb_q.ra_we;
  assign SPWrite      = wb_q.sp_we;
  assign MarySrc      = wb_q.mary_src;
  assign SPSrc        = wb_q.sp_src;
  assign ShelleySrc   = wb_q.shelley_src;
  assign RASrc        = wb_q.ra_src;
  assign RegDst       = wb_q.reg_dst;
  assign RegData      = wb_q.reg_data;
  assign PCWrite      = pc_we_q;
  assign PCSrc        = (jcmp_q && !comp) ? PC_NEXT : pcsrc_q;
  assign ALUOP        = aluop_q;
  assign SrcA         = srca_q;
  assign SrcB         = srcb_q;
  assign state        = state_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit with hand-computed expectations.
module tb_multicycle_control_unit;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [4:0] OPCODE;
  logic       flagbit, comp, mem_ready;
  logic       IRWrite, MemRead, MemWrite;
  logic [2:0] MemSrc, MemDst;
  logic       RegWrite, MaryWrite, ShelleyWrite, CompWrite, RAWrite, PCWrite, SPWrite;
  logic [1:0] MarySrc, SPSrc;
  logic       ShelleySrc, RASrc, RegDst, RegData, SrcA, SrcB;
  logic [2:0] PCSrc;
  logic [2:0] ALUOP;
  logic [2:0] state;
  logic       illegal;
  logic [9:0] en_all;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  multicycle_control_unit #(.OPCODE_W(5), .ALUOP_W(3), .FETCH_TIMEOUT(15)) dut (
    .CLK(CLK), .Reset(Reset), .OPCODE(OPCODE), .flagbit(flagbit), .comp(comp),
    .mem_ready(mem_ready), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemSrc(MemSrc), .MemDst(MemDst), .RegWrite(RegWrite), .MaryWrite(MaryWrite),
    .ShelleyWrite(ShelleyWrite), .CompWrite(CompWrite), .RAWrite(RAWrite),
    .PCWrite(PCWrite), .SPWrite(SPWrite), .MarySrc(MarySrc), .SPSrc(SPSrc),
    .ShelleySrc(ShelleySrc), .RASrc(RASrc), .RegDst(RegDst), .RegData(RegData),
    .SrcA(SrcA), .SrcB(SrcB), .PCSrc(PCSrc), .ALUOP(ALUOP), .state(state),
    .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  assign en_all = {IRWrite, MemRead, MemWrite, RegWrite, MaryWrite, ShelleyWrite,
                   CompWrite, RAWrite, PCWrite, SPWrite};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; OPCODE = 5'b00000; flagbit = 1'b0; comp = 1'b0; mem_ready = 1'b0;
    #2;
    check("rst_state",   32'(state),   0);
    check("rst_illegal", 32'(illegal), 0);
    check("rst_enables", 32'(en_all),  0);
    check("rst_pcsrc",   32'(PCSrc),   0);
    cyc();
    Reset = 1'b0;

    // AADD, flagbit=1: FETCH, DECODE, EXEC, WB, FETCH
    OPCODE = 5'b00010; flagbit = 1'b1; mem_ready = 1'b1;
    #1;
    check("aadd_fetch_state",  32'(state),   0);
    check("aadd_fetch_memrd",  32'(MemRead), 1);
    check("aadd_fetch_memdst", 32'(MemDst),  0);
    check("aadd_fetch_irw",    32'(IRWrite), 1);
    cyc();
    check("aadd_dec_state", 32'(state),   1);
    check("aadd_dec_irw",   32'(IRWrite), 0);
    cyc();
    check("aadd_exec_state", 32'(state), 2);
    check("aadd_exec_aluop", 32'(ALUOP), 2);
    cyc();
    check("aadd_wb_state",   32'(state),     4);
    check("aadd_wb_aluop",   32'(ALUOP),     2);
    check("aadd_wb_srca",    32'(SrcA),      0);
    check("aadd_wb_srcb",    32'(SrcB),      0);
    check("aadd_wb_marywe",  32'(MaryWrite), 1);
    check("aadd_wb_marysrc", 32'(MarySrc),   1);
    check("aadd_wb_pcwe",    32'(PCWrite),   1);
    check("aadd_wb_pcsrc",   32'(PCSrc),     0);
    cyc();
    check("aadd_c5_state",  32'(state),     0);
    check("aadd_c5_marywe", 32'(MaryWrite), 0);
    check("aadd_c5_pcwe",   32'(PCWrite),   0);

    // SPOP with a stalled memory read (mem_ready high in DECODE is ignored)
    OPCODE = 5'b00101; flagbit = 1'b0;
    cyc();
    check("spop_dec_state", 32'(state), 1);
    cyc();
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("spop_mem_state",  32'(state),   3);
      check("spop_mem_memrd",  32'(MemRead), 1);
      check("spop_mem_memdst", 32'(MemDst),  4);
      check("spop_mem_spwe",   32'(SPWrite), 0);
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    check("spop_done_state", 32'(state),   3);
    check("spop_done_memrd", 32'(MemRead), 1);
    cyc();
    check("spop_wb_state",   32'(state),     4);
    check("spop_wb_spwe",    32'(SPWrite),   1);
    check("spop_wb_spsrc",   32'(SPSrc),     2);
    check("spop_wb_marywe",  32'(MaryWrite), 1);
    check("spop_wb_marysrc", 32'(MarySrc),   0);
    check("spop_wb_memrd",   32'(MemRead),   0);
    check("spop_wb_pcwe",    32'(PCWrite),   1);
    cyc();
    check("spop_post_state",  32'(state),     0);
    check("spop_post_spwe",   32'(SPWrite),   0);
    check("spop_post_marywe", 32'(MaryWrite), 0);
    check("spop_post_memdst", 32'(MemDst),    0);

    // JCMP flagbit=1: comp low in DECODE, high in WB -> taken (111)
    OPCODE = 5'b01001; flagbit = 1'b1; comp = 1'b0;
    cyc();
    cyc();
    comp = 1'b1;
    #1;
    check("jcmp1_wb_state", 32'(state),   4);
    check("jcmp1_wb_pcsrc", 32'(PCSrc),   7);
    check("jcmp1_wb_pcwe",  32'(PCWrite), 1);
    cyc();
    check("jcmp1_post_state", 32'(state), 0);

    // JCMP flagbit=1: comp high in DECODE, low in WB -> not taken (000)
    comp = 1'b1;
    cyc();
    cyc();
    comp = 1'b0;
    #1;
    check("jcmp0_wb_state", 32'(state),   4);
    check("jcmp0_wb_pcsrc", 32'(PCSrc),   0);
    check("jcmp0_wb_pcwe",  32'(PCWrite), 1);
    cyc();

    // JFNC flagbit=0: three cycles, links RA from PC
    OPCODE = 5'b01011; flagbit = 1'b0;
    cyc();
    cyc();
    check("jfnc_wb_state", 32'(state),   4);
    check("jfnc_wb_rawe",  32'(RAWrite), 1);
    check("jfnc_wb_rasrc", 32'(RASrc),   1);
    check("jfnc_wb_pcsrc", 32'(PCSrc),   2);
    check("jfnc_wb_pcwe",  32'(PCWrite), 1);
    cyc();
    check("jfnc_c4_state", 32'(state),   0);
    check("jfnc_c4_rawe",  32'(RAWrite), 0);

    // JACC flagbit=1 -> 101
    OPCODE = 5'b01000; flagbit = 1'b1;
    cyc();
    cyc();
    check("jacc_wb_pcsrc", 32'(PCSrc), 5);
    cyc();

    // SPUT aborted by Reset mid-MEM
    OPCODE = 5'b00001; flagbit = 1'b0;
    cyc();
    mem_ready = 1'b0;
    cyc();
    check("sput_mem_state", 32'(state),    3);
    check("sput_mem_memwr", 32'(MemWrite), 1);
    check("sput_mem_memrd", 32'(MemRead),  0);
    #2;
    Reset = 1'b1;
    #1;
    check("sput_rst_memwr",   32'(MemWrite), 0);
    check("sput_rst_state",   32'(state),    0);
    check("sput_rst_illegal", 32'(illegal),  0);
    check("sput_rst_spwe",    32'(SPWrite),  0);
    cyc();
    check("sput_rst_enables", 32'(en_all), 0);
    Reset = 1'b0;
    cyc();
    check("sput_after_state", 32'(state),   0);
    check("sput_after_spwe",  32'(SPWrite), 0);

    // Illegal opcode traps and stays trapped
    OPCODE = 5'b11111; mem_ready = 1'b1;
    cyc();
    cyc();
    check("ill_state",   32'(state),   7);
    check("ill_illegal", 32'(illegal), 1);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      #1;
      check("trap_state",   32'(state),   7);
      check("trap_illegal", 32'(illegal), 1);
      check("trap_enables", 32'(en_all),  0);
      cyc();
    end

    // Fetch timeout: 15 FETCH cycles without mem_ready
    Reset = 1'b1; mem_ready = 1'b0; OPCODE = 5'b00010;
    cyc();
    Reset = 1'b0;
    #1;
    check("to_start_state",   32'(state),   0);
    check("to_start_illegal", 32'(illegal), 0);
    repeat (14) cyc();
    check("to_14_state", 32'(state),   0);
    check("to_14_memrd", 32'(MemRead), 1);
    cyc();
    check("to_15_state", 32'(state), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
